fsm_dispatcher: RTL and testbench

Upstream job dispatcher for the `fsm` controller. It accepts job IDs over a valid/ready request port and queues them in a small FIFO. For each queued job it issues a one-cycle `start` pulse to `fsm`, waits for `done` under a cycle-count timeout, and reports each job's completion or timeout on a valid/ready completion port. At most one job is in flight in `fsm` at a time.

---
 rtl/fsm_dispatcher.sv | 136 +++++++++++++
 tb/tb_fsm_dispatcher.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_dispatcher.sv
// ============================================================================
// fsm_dispatcher : queues job IDs, launches them one at a time into fsm,
//                  and reports completion or timeout for each job.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fsm_dispatcher #(
  parameter int ID_W    = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [ID_W-1:0]          req_id,
  output logic                     req_ready,
  output logic                     start,
  input  logic                     done,
  output logic                     cmp_valid,
  output logic [ID_W-1:0]          cmp_id,
  output logic                     cmp_timeout,
  input  logic                     cmp_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [TMR_W-1:0]  timer;
  logic              push;
  logic              pop;
  logic              rep_load;
  logic              rep_timeout;

  // No full-bypass: a full FIFO refuses even when a pop happens this cycle.
  assign req_ready = !rst && (count < CNT_FULL);
  assign push      = req_valid && req_ready;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    rep_load    = 1'b0;
    rep_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT: begin
        // done takes priority over a timeout expiring in the same cycle
        if (done) begin
          rep_load   = 1'b1;
          state_next = S_REPORT;
        end else if (timer == TMR_LAST) begin
          rep_load    = 1'b1;
          rep_timeout = 1'b1;
          state_next  = S_REPORT;
        end
      end
      S_REPORT: begin
        if (cmp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cur_id      <= '0;
      timer       <= '0;
      start       <= 1'b0;
      cmp_valid   <= 1'b0;
      cmp_id      <= '0;
      cmp_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cur_id <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // start is high exactly while the FSM sits in LAUNCH
      start <= pop;
      if (state == S_LAUNCH)    timer <= '0;
      else if (state == S_WAIT) timer <= timer + 1'b1;
      if (rep_load) begin
        cmp_valid   <= 1'b1;
        cmp_id      <= cur_id;
        cmp_timeout <= rep_timeout;
      end else if (cmp_valid && cmp_ready) begin
        cmp_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fsm_dispatcher.sv
// ============================================================================
// tb_fsm_dispatcher : scoreboard bench for fsm_dispatcher.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_fsm_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_id = 4'h0;
  logic       done = 1'b0;
  logic       cmp_ready = 1'b1;
  logic       req_ready;
  logic       start;
  logic       cmp_valid;
  logic [3:0] cmp_id;
  logic       cmp_timeout;
  logic       busy;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;
  logic [4:0] expq [$];

  fsm_dispatcher #(.ID_W(4), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_ready  (req_ready),
    .start      (start),
    .done       (done),
    .cmp_valid  (cmp_valid),
    .cmp_id     (cmp_id),
    .cmp_timeout(cmp_timeout),
    .cmp_ready  (cmp_ready),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion handshake is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    logic [4:0] e;
    if (!rst && cmp_valid && cmp_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_record: got id %0d timeout %0d expected no record", cmp_id, cmp_timeout);
      end else begin
        e = expq.pop_front();
        check("cmp_id", int'(cmp_id), int'(e[3:0]));
        check("cmp_timeout", int'(cmp_timeout), int'(e[4]));
      end
    end
  end

  task automatic run_job(input logic [3:0] id, input int done_cyc, input logic exp_to, input int exp_lat);
    int n;
    int c;
    bit got;
    req_valid = 1'b1;
    req_id    = id;
    expq.push_back({exp_to, id});
    step();
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!start && n < 10) begin
      step();
      @(negedge clk);
      n++;
    end
    check("start_latency", n, 1);
    step();
    @(negedge clk);
    check("start_one_cycle", int'(start), 0);
    c   = 1;
    got = 1'b0;
    while (!got && c <= 40) begin
      done = (c == done_cyc);
      step();
      done = 1'b0;
      @(negedge clk);
      if (cmp_valid) got = 1'b1;
      else c++;
    end
    check("report_latency", c, exp_lat);
    step();
    @(negedge clk);
    check("busy_after_job", int'(busy), 0);
    check("valid_after_job", int'(cmp_valid), 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || count != 3'd0) && n < 300) begin
      step();
      @(negedge clk);
      n++;
    end
    check(name, int'(n < 300), 1);
    check({name, "_scoreboard"}, expq.size(), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int v;
    // Reset state
    step();
    step();
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_start", int'(start), 0);
    check("rst_cmp_valid", int'(cmp_valid), 0);
    check("rst_cmp_id", int'(cmp_id), 0);
    check("rst_cmp_timeout", int'(cmp_timeout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    step();
    rst = 1'b0;

    // Single job, done in WAIT cycle 3
    run_job(4'h3, 3, 1'b0, 3);
    // Timeout, then done/timeout tie, then a done in the first WAIT cycle
    run_job(4'hA, 0, 1'b1, 16);
    run_job(4'h2, 16, 1'b0, 16);
    run_job(4'hC, 1, 1'b0, 1);

    // Queue full: IDs 1..5 accepted back-to-back, 6 stalls until job 1 times out
    for (int i = 1; i <= 5; i++) begin
      req_valid = 1'b1;
      req_id    = 4'(i);
      expq.push_back({1'b1, 4'(i)});
      step();
    end
    @(negedge clk);
    check("full_count", int'(count), 4);
    check("full_req_ready", int'(req_ready), 0);
    check("full_busy", int'(busy), 1);
    req_id = 4'h6;
    expq.push_back({1'b1, 4'h6});
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
      @(negedge clk);
    end
    check("full_stall_cycles", n, 16);
    check("full_first_done", expq.size(), 5);
    step();
    req_valid = 1'b0;
    wait_idle("full_drain");

    // Completion backpressure
    cmp_ready = 1'b0;
    req_valid = 1'b1;
    req_id    = 4'h7;
    expq.push_back({1'b0, 4'h7});
    step();
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!start && n < 10) begin
      step();
      @(negedge clk);
      n++;
    end
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    @(negedge clk);
    check("bp_valid_rise", int'(cmp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        req_valid = 1'b1;
        req_id    = 4'h8;
        expq.push_back({1'b1, 4'h8});
      end
      if (i == 1) begin
        req_id = 4'h9;
        expq.push_back({1'b1, 4'h9});
      end
      if (i == 2) req_valid = 1'b0;
      step();
      @(negedge clk);
      check("bp_valid", int'(cmp_valid), 1);
      check("bp_id", int'(cmp_id), 7);
      check("bp_timeout", int'(cmp_timeout), 0);
      check("bp_no_start", int'(start), 0);
    end
    check("bp_queued", int'(count), 2);
    step();
    cmp_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_idle_start", int'(start), 0);
    check("bp_idle_busy", int'(busy), 0);
    step();
    @(negedge clk);
    check("bp_launch_start", int'(start), 1);
    wait_idle("bp_drain");

    // Reset mid-WAIT with two jobs queued
    req_valid = 1'b1;
    req_id    = 4'hB;
    step();
    req_id = 4'hD;
    step();
    req_id = 4'hE;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_count", int'(count), 2);
    check("pre_rst_busy", int'(busy), 1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_start", int'(start), 0);
    check("mid_rst_valid", int'(cmp_valid), 0);
    check("mid_rst_ready", int'(req_ready), 0);
    step();
    rst  = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    v = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmp_valid || start) v++;
      step();
    end
    check("post_rst_activity", v, 0);
    check("post_rst_busy", int'(busy), 0);

    // Recovery after reset
    run_job(4'h5, 2, 1'b0, 2);
    check("final_scoreboard", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
